// File: rtl/holy_core_pkg.sv
// Shared types for the holy core memory path: arbiter FSM state, port owner, latched request.
// Latency: none, types and a pure helper function only.
// Backpressure: n/a.
package holy_core_pkg;

    // Widths of the unified memory port carried in mem_req_t.
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } arb_owner_t;

    // Request fields held stable on the memory port for the whole transaction.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
        logic                  we;
    } mem_req_t;

    // Instruction fetches are always full-word loads.
    function automatic mem_req_t fetch_req(input logic [MEM_ADDR_W-1:0] addr);
        mem_req_t r;
        r.addr  = addr;
        r.wdata = '0;
        r.be    = '1;
        r.we    = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/holy_mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); D wins unless I has waited MAX_D_STREAK D grants.
// Latency: grant in IDLE, mem_valid next cycle, ack combinational with mem_rvalid; 3 cycles per transaction minimum.
// Backpressure: mem_valid and fields held until mem_ready; requesters stall until their ack.
module holy_mem_arbiter
    import holy_core_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_stall,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_stall,

    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    // The latched request struct is sized by the package, so the port widths must agree with it.
    if (ADDR_W != MEM_ADDR_W || DATA_W != MEM_DATA_W) begin : g_width_check
        $error("holy_mem_arbiter: ADDR_W/DATA_W must match holy_core_pkg MEM_ADDR_W/MEM_DATA_W");
    end
    if (MAX_D_STREAK < 1) begin : g_streak_check
        $error("holy_mem_arbiter: MAX_D_STREAK must be >= 1");
    end

    arb_state_t          state;
    arb_owner_t          owner;
    logic [STREAK_W-1:0] streak;
    mem_req_t            req_q;
    logic                mem_valid_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                resp_fire;
    logic                i_starved;
    logic                grant_d;
    logic                grant_i;
    logic [STREAK_W-1:0] streak_inc;

    // I is forced through once D has won MAX_D_STREAK times in a row while I was waiting.
    assign i_starved  = i_req && (streak == STREAK_MAX);
    assign grant_d    = d_req && !i_starved;
    assign grant_i    = !grant_d && i_req;
    assign streak_inc = (streak == STREAK_MAX) ? streak : streak + STREAK_ONE;

    // Acks and read data come straight from mem_rvalid so the core can unfreeze in the same cycle.
    assign resp_fire = (state == ARB_RESP) && mem_rvalid;
    assign i_ack     = resp_fire && (owner == OWNER_I);
    assign d_ack     = resp_fire && (owner == OWNER_D);
    assign i_rdata   = i_ack ? mem_rdata : i_rdata_q;
    assign d_rdata   = d_ack ? mem_rdata : d_rdata_q;
    assign i_stall   = i_req && !i_ack;
    assign d_stall   = d_req && !d_ack;

    assign mem_valid = mem_valid_q;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_be    = req_q.be;
    assign mem_we    = req_q.we;

    // Arbitration FSM: grant and latch in IDLE, present the request in REQ, wait for the response in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            owner       <= OWNER_I;
            streak      <= '0;
            req_q       <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        owner       <= OWNER_D;
                        req_q.addr  <= d_addr;
                        req_q.wdata <= d_wdata;
                        req_q.be    <= d_be;
                        req_q.we    <= d_we;
                        streak      <= i_req ? streak_inc : '0;
                        mem_valid_q <= 1'b1;
                        state       <= ARB_REQ;
                    end else if (grant_i) begin
                        owner       <= OWNER_I;
                        req_q       <= fetch_req(i_addr);
                        streak      <= '0;
                        mem_valid_q <= 1'b1;
                        state       <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    // mem_rvalid here is a memory-side protocol error and is deliberately ignored.
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state       <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (mem_rvalid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    state       <= ARB_IDLE;
                end
            endcase
        end
    end

    // Hold each requester's last read data until its next ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_ack) begin
                i_rdata_q <= mem_rdata;
            end
            if (d_ack) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/holy_mem_arbiter.md
Name: holy_mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (I-side) and the load/store requester (D-side) of the pipelined core.
- Grants one transaction at a time and drives a valid/ready request channel plus an rvalid response channel toward memory.
- Returns a one-cycle ack and read data to the owning requester; the core uses the stall outputs to freeze its pipeline registers.
- D-side has fixed priority, with a bounded-streak rule so fetch cannot starve.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8.
- MAX_D_STREAK, 4, max consecutive D grants while I is pending before I is forced; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data; valid when i_ack=1.
- i_ack  out  1  one-cycle completion pulse for I.
- i_stall  out  1  i_req && !i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data; valid when d_ack=1.
- d_ack  out  1  one-cycle completion pulse for D.
- d_stall  out  1  d_req && !d_ack.
- mem_valid  out  1  request valid.
- mem_ready  in  1  memory accepts request.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields.
- mem_rvalid  in  1  response valid; also signals store completion.
- mem_rdata  in  DATA_W  response data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State = IDLE, owner = I, streak = 0.
  - mem_valid, i_ack and d_ack = 0.
  - mem_addr, mem_wdata, mem_be and mem_we = 0.
  - i_rdata and d_rdata = 0.
- Reset mid-transaction: state returns to IDLE immediately and any in-flight response is dropped. Memory is reset alongside.

States:
- IDLE:
  - No request: stay.
  - Arbitrate. If d_req && !(i_req && streak==MAX_D_STREAK), grant D; else if i_req, grant I.
  - On grant: latch owner and request fields (I-side: we=0, be=all ones, wdata=0), go to REQ.
- REQ:
  - mem_valid=1 with fields stable.
  - mem_ready=1: go to RESP.
  - mem_rvalid in REQ is ignored (protocol violation; assertion in bench).
- RESP:
  - Wait for mem_rvalid.
  - On mem_rvalid: owner's ack=1 and owner's rdata=mem_rdata, both in the same cycle (combinational from mem_rvalid); go to IDLE.
  - rdata outputs are held until the next ack.

Streak rule:
- Granting D while i_req=1: streak+1, saturating at MAX_D_STREAK.
- Granting I, or i_req=0 at the grant: streak=0.

Latency and throughput:
- Minimum with mem_ready=1 and rvalid in the first RESP cycle: request seen in IDLE at cycle 0; mem_valid at cycle 1; ack at cycle 2; IDLE again at cycle 3.
- Back-to-back transactions therefore take 3 cycles each.

Requester and port rules:
- Requests, and the fields of a granted request, are sampled only in IDLE. Changes while a requester is not yet granted take effect at its grant.
- The non-owner's ack is 0 throughout.
- A requester dropping req after grant does not abort the transaction; the ack still fires.
- Stall outputs are combinational.

Decomposition:
- Add to holy_core_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_RESP}.
  - arb_owner_t enum {OWNER_I, OWNER_D}.
  - mem_req_t packed struct {addr, wdata, be, we}.
- Single module; no sub-module.
- The streak counter is log2(MAX_D_STREAK+1) bits, inline.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x0000_0010, mem_ready=1, rvalid next cycle with rdata=0x0010_0093.
   -> mem_valid at cycle 1 with addr 0x10 and be=4'hF; i_ack and i_rdata=0x0010_0093 at cycle 2; i_stall=1 at cycles 0-1.
2. Collision: i_req and d_req both asserted at cycle 0, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=4'b0011.
   -> D granted first, with mem fields exactly those values; d_ack at cycle 2; I granted at cycle 3; i_ack at cycle 5.
3. Starvation bound: i_req and d_req held high, MAX_D_STREAK=4.
   -> grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I grant.
4. Backpressure: mem_ready=0 for 5 cycles, then 1; rvalid delayed 3 cycles.
   -> mem_valid held with stable fields for 6 cycles; exactly one ack.
5. Reset mid-op: assert rst in RESP.
   -> same-cycle outputs go to reset values; a subsequent mem_rvalid produces no ack; a new i_req after reset completes normally.
6. Dropped request: d_req deasserted one cycle after grant.
   -> d_ack still pulses on rvalid; no second transaction is issued.
